uart_loopback_bridge: RTL and testbench

UART_LOOPBACK_BRIDGE -- requirements
Module: uart_loopback_bridge

---
 rtl/uart_loopback_bridge_pkg.sv | 25 ++
 rtl/uart_loopback_bridge_fifo.sv | 76 +++++++
 rtl/uart_loopback_bridge.sv | 142 ++++++++++++++
 tb/tb_uart_loopback_bridge.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loopback_bridge_pkg.sv
// Shared types and constants for the UART loopback bridge.
// Holds the RX/TX state encodings, the TX busy timeout and a saturating-increment helper.
package uart_loopback_bridge_pkg;

   typedef enum logic {
      R_IDLE,
      R_GAP
   } rx_state_e;

   typedef enum logic [1:0] {
      T_IDLE,
      T_SEND,
      T_BUSY,
      T_DONE
   } tx_state_e;

   // Cycles T_BUSY tolerates tr_ready staying high before assuming the transmitter missed the launch
   localparam int unsigned BUSY_TIMEOUT = 4;
   localparam int unsigned BUSY_CNT_W   = $clog2(BUSY_TIMEOUT);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart_loopback_bridge_fifo.sv
// Byte FIFO between the RX and TX sides: array storage, registered read port.
// The read register doubles as the transmit data holding register.
module byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic                     wr_en,
   input  logic [7:0]               wr_data,
   input  logic                     rd_en,
   output logic [7:0]               rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic [7:0]    rd_data_q, rd_data_d;
   logic          do_wr, do_rd;

   assign full  = (level_q == FULL_LVL);
   assign empty = (level_q == '0);
   assign level = level_q;
   assign rd_data = rd_data_q;

   // A write into a full FIFO is only accepted when a read frees a slot in the same cycle
   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      rd_data_d = rd_data_q;
      if (do_wr) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
         rd_ptr_d  = rd_ptr_q + 1'b1;
         rd_data_d = mem[rd_ptr_q];
      end
      case ({do_wr, do_rd})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         rd_data_q <= 8'h00;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Storage kept out of the reset block so it maps onto RAM
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/uart_loopback_bridge.sv
// Loops bytes from a UART receiver back to a UART transmitter through a byte FIFO.
// RX FSM pops with a minimum two-cycle spacing; TX FSM launches one byte per transmitter handshake.
module uart_loopback_bridge
   import uart_loopback_bridge_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int DROP_ERR = 1
) (
   input  logic                    mclk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [7:0]              rd_data,
   input  logic                    rd_valid,
   input  logic                    frame_err,
   input  logic                    parity_err,
   output logic                    read_en,
   input  logic                    tr_ready,
   output logic [7:0]              tr_data,
   output logic                    send_en,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic                    overflow,
   output logic [7:0]              err_cnt,
   output logic [15:0]             tx_cnt
);

   rx_state_e              rx_state_q, rx_state_d;
   tx_state_e              tx_state_q, tx_state_d;
   logic [BUSY_CNT_W-1:0]  busy_cnt_q, busy_cnt_d;
   logic                   overflow_q, overflow_d;
   logic [7:0]             err_cnt_q, err_cnt_d;
   logic [15:0]            tx_cnt_q, tx_cnt_d;

   logic pop_rx;
   logic rx_err;
   logic fifo_wr;
   logic fifo_rd;
   logic fifo_full;
   logic fifo_empty;

   always_comb begin
      rx_state_d = rx_state_q;
      pop_rx     = 1'b0;
      case (rx_state_q)
         R_IDLE: begin
            if (enable && rd_valid && !fifo_full) begin
               pop_rx     = 1'b1;
               rx_state_d = R_GAP;
            end
         end
         R_GAP:   rx_state_d = R_IDLE;
         default: rx_state_d = R_IDLE;
      endcase
   end

   // Strobes are masked during reset so an aborted transfer never leaks a pop or a launch
   assign read_en = pop_rx && !reset;
   assign rx_err  = frame_err || parity_err;
   assign fifo_wr = read_en && !((DROP_ERR != 0) && rx_err);

   always_comb begin
      tx_state_d = tx_state_q;
      busy_cnt_d = busy_cnt_q;
      tx_cnt_d   = tx_cnt_q;
      fifo_rd    = 1'b0;
      case (tx_state_q)
         T_IDLE: begin
            if (enable && !fifo_empty && tr_ready) begin
               fifo_rd    = 1'b1;
               tx_state_d = T_SEND;
            end
         end
         T_SEND: begin
            tx_cnt_d   = tx_cnt_q + 16'd1;
            busy_cnt_d = '0;
            tx_state_d = T_BUSY;
         end
         T_BUSY: begin
            if (!tr_ready || (busy_cnt_q == BUSY_CNT_W'(BUSY_TIMEOUT - 1))) begin
               tx_state_d = T_DONE;
            end else begin
               busy_cnt_d = busy_cnt_q + 1'b1;
            end
         end
         T_DONE: begin
            if (tr_ready) begin
               tx_state_d = T_IDLE;
            end
         end
         default: tx_state_d = T_IDLE;
      endcase
   end

   assign send_en = (tx_state_q == T_SEND) && !reset;

   always_comb begin
      err_cnt_d  = err_cnt_q;
      overflow_d = overflow_q;
      if (read_en && rx_err) begin
         err_cnt_d = sat_inc8(err_cnt_q);
      end
      if (fifo_wr && fifo_full && !fifo_rd) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge mclk) begin
      if (reset) begin
         rx_state_q <= R_IDLE;
         tx_state_q <= T_IDLE;
         busy_cnt_q <= '0;
         overflow_q <= 1'b0;
         err_cnt_q  <= 8'h00;
         tx_cnt_q   <= 16'h0000;
      end else begin
         rx_state_q <= rx_state_d;
         tx_state_q <= tx_state_d;
         busy_cnt_q <= busy_cnt_d;
         overflow_q <= overflow_d;
         err_cnt_q  <= err_cnt_d;
         tx_cnt_q   <= tx_cnt_d;
      end
   end

   assign overflow = overflow_q;
   assign err_cnt  = err_cnt_q;
   assign tx_cnt   = tx_cnt_q;

   byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (mclk),
      .srst    (reset),
      .wr_en   (fifo_wr),
      .wr_data (rd_data),
      .rd_en   (fifo_rd),
      .rd_data (tr_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

endmodule

// File: tb/tb_uart_loopback_bridge.sv
// Directed bench: two bridges (DROP_ERR=1 and DROP_ERR=0) fed the same RX byte stream,
// each with its own RX source pointer and transmitter model.
module tb_uart_loopback_bridge;

   logic mclk;
   logic reset;
   logic enable;
   int   tr_mode;   // 0 = transmitter busy 10 cycles per byte, 1 = tr_ready held 0, 2 = tr_ready stuck 1
   int   cyc;
   int   n_tests;
   int   n_fail;

   logic [9:0] rx_mem [1024];   // {parity_err, frame_err, data}
   int         rx_wr;

   initial begin
      mclk = 1'b0;
      forever #5 mclk = ~mclk;
   end

   always @(posedge mclk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      logic        read_en, send_en, overflow, rd_valid, tr_ready;
      logic [7:0]  tr_data, err_cnt;
      logic [15:0] tx_cnt;
      logic [3:0]  fifo_level;
      logic [9:0]  rx_word;
      int          rx_rd, busy, rd_pulses, sent_n;
      logic [7:0]  sent_log [16];
      int          send_cyc [16];

      assign rd_valid = (rx_rd != rx_wr);
      assign rx_word  = rx_mem[rx_rd % 1024];
      assign tr_ready = (tr_mode == 1) ? 1'b0 : (tr_mode == 2) ? 1'b1 : (busy == 0);

      uart_loopback_bridge #(
         .DEPTH    (8),
         .DROP_ERR ((gi == 0) ? 1 : 0)
      ) u_dut (
         .mclk       (mclk),
         .reset      (reset),
         .enable     (enable),
         .rd_data    (rx_word[7:0]),
         .rd_valid   (rd_valid),
         .frame_err  (rx_word[8]),
         .parity_err (rx_word[9]),
         .read_en    (read_en),
         .tr_ready   (tr_ready),
         .tr_data    (tr_data),
         .send_en    (send_en),
         .fifo_level (fifo_level),
         .overflow   (overflow),
         .err_cnt    (err_cnt),
         .tx_cnt     (tx_cnt)
      );

      always @(posedge mclk) begin
         if (reset) begin
            rx_rd     <= rx_wr;
            busy      <= 0;
            rd_pulses <= 0;
            sent_n    <= 0;
         end else begin
            if (read_en) begin
               rx_rd     <= rx_rd + 1;
               rd_pulses <= rd_pulses + 1;
            end
            if (send_en) begin
               busy <= 10;
               if (sent_n < 16) begin
                  sent_log[sent_n] <= tr_data;
                  send_cyc[sent_n] <= cyc;
               end
               sent_n <= sent_n + 1;
            end else if (busy != 0) begin
               busy <= busy - 1;
            end
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic push_rx(input logic [7:0] b, input logic fe, input logic pe);
      rx_mem[rx_wr % 1024] = {pe, fe, b};
      rx_wr = rx_wr + 1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge mclk);
      reset = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rx_wr   = 0;
      tr_mode = 0;
      enable  = 1'b1;
      reset   = 1'b1;
      @(negedge mclk);
      do_reset();

      // Reset state
      check_eq("rst_read_en",  32'(g_inst[0].read_en), 32'd0);
      check_eq("rst_send_en",  32'(g_inst[0].send_en), 32'd0);
      check_eq("rst_tr_data",  32'(g_inst[0].tr_data), 32'h00);
      check_eq("rst_level",    32'(g_inst[0].fifo_level), 32'd0);
      check_eq("rst_overflow", 32'(g_inst[0].overflow), 32'd0);
      check_eq("rst_err_cnt",  32'(g_inst[0].err_cnt), 32'd0);
      check_eq("rst_tx_cnt",   32'(g_inst[0].tx_cnt), 32'd0);

      // Single clean byte through a 10-cycle-busy transmitter
      push_rx(8'hA5, 1'b0, 1'b0);
      repeat (40) @(negedge mclk);
      check_eq("a5_read_pulses", 32'(g_inst[0].rd_pulses), 32'd1);
      check_eq("a5_sends",       32'(g_inst[0].sent_n), 32'd1);
      check_eq("a5_data",        32'(g_inst[0].sent_log[0]), 32'hA5);
      check_eq("a5_tx_cnt",      32'(g_inst[0].tx_cnt), 32'd1);
      check_eq("a5_tr_data_hold", 32'(g_inst[0].tr_data), 32'hA5);
      check_eq("a5_level",       32'(g_inst[0].fifo_level), 32'd0);

      // Parity-flagged byte followed by a clean one, dropped vs forwarded
      do_reset();
      push_rx(8'h11, 1'b0, 1'b1);
      push_rx(8'h22, 1'b0, 1'b0);
      repeat (60) @(negedge mclk);
      check_eq("drop1_sends",   32'(g_inst[0].sent_n), 32'd1);
      check_eq("drop1_data0",   32'(g_inst[0].sent_log[0]), 32'h22);
      check_eq("drop1_err_cnt", 32'(g_inst[0].err_cnt), 32'd1);
      check_eq("drop0_sends",   32'(g_inst[1].sent_n), 32'd2);
      check_eq("drop0_data0",   32'(g_inst[1].sent_log[0]), 32'h11);
      check_eq("drop0_data1",   32'(g_inst[1].sent_log[1]), 32'h22);
      check_eq("drop0_err_cnt", 32'(g_inst[1].err_cnt), 32'd1);

      // enable low: nothing popped until it rises
      do_reset();
      enable = 1'b0;
      push_rx(8'h77, 1'b0, 1'b0);
      repeat (10) @(negedge mclk);
      check_eq("en0_read_pulses", 32'(g_inst[0].rd_pulses), 32'd0);
      check_eq("en0_sends",       32'(g_inst[0].sent_n), 32'd0);
      enable = 1'b1;
      repeat (20) @(negedge mclk);
      check_eq("en1_read_pulses", 32'(g_inst[0].rd_pulses), 32'd1);
      check_eq("en1_data",        32'(g_inst[0].sent_log[0]), 32'h77);

      // Transmitter stalled, 10 bytes offered into an 8-deep FIFO
      do_reset();
      tr_mode = 1;
      for (int i = 0; i < 10; i++) push_rx(8'(8'h30 + i), 1'b0, 1'b0);
      repeat (40) @(negedge mclk);
      check_eq("full_read_pulses", 32'(g_inst[0].rd_pulses), 32'd8);
      check_eq("full_level",       32'(g_inst[0].fifo_level), 32'd8);
      check_eq("full_overflow",    32'(g_inst[0].overflow), 32'd0);
      check_eq("full_sends",       32'(g_inst[0].sent_n), 32'd0);
      tr_mode = 0;
      repeat (250) @(negedge mclk);
      check_eq("drain_sends", 32'(g_inst[0].sent_n), 32'd10);
      for (int i = 0; i < 10; i++) begin
         check_eq($sformatf("drain_data%0d", i), 32'(g_inst[0].sent_log[i]), 32'(8'h30 + i));
      end
      check_eq("drain_overflow", 32'(g_inst[0].overflow), 32'd0);
      check_eq("drain_level",    32'(g_inst[0].fifo_level), 32'd0);

      // tr_ready stuck high: T_BUSY times out, next launch 7 cycles after the first
      do_reset();
      tr_mode = 2;
      push_rx(8'h5A, 1'b0, 1'b0);
      push_rx(8'h6B, 1'b0, 1'b0);
      repeat (40) @(negedge mclk);
      check_eq("stuck_sends",  32'(g_inst[0].sent_n), 32'd2);
      check_eq("stuck_data0",  32'(g_inst[0].sent_log[0]), 32'h5A);
      check_eq("stuck_data1",  32'(g_inst[0].sent_log[1]), 32'h6B);
      check_eq("stuck_gap",    32'(g_inst[0].send_cyc[1] - g_inst[0].send_cyc[0]), 32'd7);
      check_eq("stuck_tx_cnt", 32'(g_inst[0].tx_cnt), 32'd2);

      // Reset while in T_BUSY with 3 bytes still queued
      do_reset();
      tr_mode = 1;
      for (int i = 0; i < 4; i++) push_rx(8'(8'hC0 + i), 1'b0, 1'b0);
      repeat (12) @(negedge mclk);
      check_eq("mid_level_pre", 32'(g_inst[0].fifo_level), 32'd4);
      tr_mode = 2;
      for (int i = 0; i < 50 && g_inst[0].sent_n == 0; i++) @(negedge mclk);
      check_eq("mid_launch",    32'(g_inst[0].sent_n), 32'd1);
      check_eq("mid_level_q3",  32'(g_inst[0].fifo_level), 32'd3);
      reset = 1'b1;
      @(negedge mclk);
      check_eq("mid_rst_send_en",  32'(g_inst[0].send_en), 32'd0);
      check_eq("mid_rst_read_en",  32'(g_inst[0].read_en), 32'd0);
      check_eq("mid_rst_tr_data",  32'(g_inst[0].tr_data), 32'h00);
      check_eq("mid_rst_level",    32'(g_inst[0].fifo_level), 32'd0);
      check_eq("mid_rst_tx_cnt",   32'(g_inst[0].tx_cnt), 32'd0);
      check_eq("mid_rst_overflow", 32'(g_inst[0].overflow), 32'd0);
      reset = 1'b0;
      repeat (30) @(negedge mclk);
      check_eq("mid_after_sends",  32'(g_inst[0].sent_n), 32'd0);
      check_eq("mid_after_tx_cnt", 32'(g_inst[0].tx_cnt), 32'd0);
      check_eq("mid_after_level",  32'(g_inst[0].fifo_level), 32'd0);

      // 300 framing-error bytes saturate err_cnt
      do_reset();
      tr_mode = 0;
      for (int i = 0; i < 300; i++) push_rx(8'(i), 1'b1, 1'b0);
      repeat (650) @(negedge mclk);
      check_eq("sat_read_pulses", 32'(g_inst[0].rd_pulses), 32'd300);
      check_eq("sat_err_cnt",     32'(g_inst[0].err_cnt), 32'd255);
      check_eq("sat_sends",       32'(g_inst[0].sent_n), 32'd0);
      check_eq("sat_level",       32'(g_inst[0].fifo_level), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
